// File: rtl/tl_initiator_pkg.sv
// Shared TileLink-UL constants, request record and alignment helpers for the
// single-beat initiator.
package tl_initiator_pkg;

    localparam int unsigned TL_SOURCE_W = 8;
    localparam int unsigned TL_SIZE_W   = 3;

    localparam logic [2:0] TL_PUT_FULL_DATA   = 3'd0;
    localparam logic [2:0] TL_GET             = 3'd4;
    localparam logic [2:0] TL_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    typedef struct packed {
        logic        write;
        logic [63:0] addr;
        logic [1:0]  size;
        logic [63:0] data;
    } req_t;

    function automatic logic [7:0] size_mask(logic [1:0] size);
        logic [7:0] mask;
        case (size)
            2'd0:    mask = 8'h01;
            2'd1:    mask = 8'h03;
            2'd2:    mask = 8'h0F;
            default: mask = 8'hFF;
        endcase
        return mask;
    endfunction

    function automatic logic misaligned(logic [2:0] addr, logic [1:0] size);
        logic bad;
        case (size)
            2'd0:    bad = 1'b0;
            2'd1:    bad = addr[0];
            2'd2:    bad = |addr[1:0];
            default: bad = |addr[2:0];
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/tl_initiator_if.sv
// TileLink-UL A/D channel bundle; master drives A and consumes D.
interface tilelink;
    import tl_initiator_pkg::*;

    logic                   a_valid;
    logic                   a_ready;
    logic [2:0]             a_opcode;
    logic [2:0]             a_param;
    logic [TL_SIZE_W-1:0]   a_size;
    logic [TL_SOURCE_W-1:0] a_source;
    logic [63:0]            a_address;
    logic [7:0]             a_mask;
    logic [63:0]            a_data;
    logic                   a_corrupt;

    logic                   d_valid;
    logic                   d_ready;
    logic [2:0]             d_opcode;
    logic [TL_SOURCE_W-1:0] d_source;
    logic                   d_denied;
    logic [63:0]            d_data;
    logic                   d_corrupt;

    modport master (
        output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
               a_corrupt, d_ready,
        input  a_ready, d_valid, d_opcode, d_source, d_denied, d_data, d_corrupt
    );

    modport slave (
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
               a_corrupt, d_ready,
        output a_ready, d_valid, d_opcode, d_source, d_denied, d_data, d_corrupt
    );

endinterface

// File: rtl/tl_initiator_dff.sv
// Plain resettable register; resets to zero asynchronously.
module tl_initiator_dff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/tl_initiator.sv
// Single-outstanding TileLink-UL initiator: turns one client Get/Put request
// into one A beat, waits for the matching D beat (or a timeout) and pulses a response.
module tl_initiator
    import tl_initiator_pkg::*;
#(
    parameter logic [TL_SOURCE_W-1:0] SOURCE_ID = '0,
    parameter int unsigned            TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic [63:0] req_data,
    output logic        rsp_valid,
    output logic [63:0] rsp_data,
    output logic        rsp_error,
    tilelink.master     bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // Counter only needs to reach TIMEOUT-1 before the timeout fires.
    localparam int unsigned     TimerW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT - 1);

    logic [1:0]        state_d, state_q;
    req_t              req_q;
    logic [TimerW-1:0] timer_q;
    logic              rsp_valid_q, rsp_error_q;
    logic [63:0]       rsp_data_q;

    logic accept, bad_align, a_fire, d_hit, timed_out, d_err;
    logic [2:0] exp_d_opcode;

    tl_initiator_dff #(
        .WIDTH (2)
    ) u_state_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (state_d),
        .q     (state_q)
    );

    always_comb begin
        req_ready    = (state_q == S_IDLE);
        accept       = req_valid && req_ready;
        bad_align    = misaligned(req_addr[2:0], req_size);
        a_fire       = (state_q == S_REQ) && bus.a_ready;
        d_hit        = (state_q == S_RESP) && bus.d_valid && (bus.d_source == SOURCE_ID);
        // A matching beat in the last cycle beats the timeout.
        timed_out    = (state_q == S_RESP) && !d_hit && (timer_q == TimerLast);
        exp_d_opcode = req_q.write ? TL_ACCESS_ACK : TL_ACCESS_ACK_DATA;
        d_err        = bus.d_denied | bus.d_corrupt | (bus.d_opcode != exp_d_opcode);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept && !bad_align) state_d = S_REQ;
            S_REQ:   if (a_fire) state_d = S_RESP;
            S_RESP:  if (d_hit || timed_out) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q       <= '0;
            timer_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            if (accept) begin
                req_q <= '{write: req_write, addr: req_addr, size: req_size, data: req_data};
                if (bad_align) begin
                    rsp_valid_q <= 1'b1;
                    rsp_error_q <= 1'b1;
                    rsp_data_q  <= '0;
                end
            end
            if (a_fire) begin
                timer_q <= '0;
            end else if ((state_q == S_RESP) && !d_hit) begin
                timer_q <= timer_q + TimerW'(1);
            end
            if (d_hit) begin
                rsp_valid_q <= 1'b1;
                rsp_error_q <= d_err;
                rsp_data_q  <= (req_q.write || d_err) ? 64'd0 : bus.d_data;
            end else if (timed_out) begin
                rsp_valid_q <= 1'b1;
                rsp_error_q <= 1'b1;
                rsp_data_q  <= '0;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_error = rsp_error_q;
    assign rsp_data  = rsp_data_q;

    assign bus.a_valid   = (state_q == S_REQ);
    assign bus.a_opcode  = req_q.write ? TL_PUT_FULL_DATA : TL_GET;
    assign bus.a_param   = 3'd0;
    assign bus.a_size    = {1'b0, req_q.size};
    assign bus.a_source  = SOURCE_ID;
    assign bus.a_address = req_q.addr;
    assign bus.a_mask    = size_mask(req_q.size);
    assign bus.a_data    = req_q.data;
    assign bus.a_corrupt = DISABLE;
    assign bus.d_ready   = (state_q == S_RESP);

endmodule

// File: tb/tb_tl_initiator.sv
// Directed and randomized transactions against a spec-level response model.
module tb_tl_initiator;

    localparam int unsigned SRC = 3;
    localparam int unsigned TMO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write;
    logic [63:0] req_addr, req_data;
    logic [1:0]  req_size;
    logic        rsp_valid, rsp_error;
    logic [63:0] rsp_data;

    int checks = 0;
    int errors = 0;

    tilelink bus ();

    tl_initiator #(
        .SOURCE_ID (8'(SRC)),
        .TIMEOUT   (TMO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_size  (req_size),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_error (rsp_error),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // d_delay = cycles in S_RESP before the beat; d_delay >= TMO means no beat at all.
    task automatic run_txn(input bit wr, input logic [63:0] addr, input logic [1:0] size,
                           input logic [63:0] data, input int a_delay, input int d_delay,
                           input logic [2:0] dop, input bit denied, input bit corrupt,
                           input logic [63:0] ddata, input bit stray);
        int          bytes;
        bit          exp_err;
        logic [63:0] exp_data;
        logic [63:0] exp_mask;
        bytes    = 1 << size;
        exp_mask = (64'd1 << bytes) - 64'd1;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_size  = size;
        req_data  = data;
        chk("req_ready_idle", req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        if ((addr % 64'(bytes)) != 0) begin
            chk("mis_rsp_valid", rsp_valid, 1);
            chk("mis_rsp_error", rsp_error, 1);
            chk("mis_rsp_data", rsp_data, 0);
            chk("mis_no_a_valid", bus.a_valid, 0);
            chk("mis_req_ready", req_ready, 1);
            @(negedge clk);
            chk("mis_rsp_pulse", rsp_valid, 0);
            chk("mis_no_a_valid2", bus.a_valid, 0);
            return;
        end
        for (int i = 0; i <= a_delay; i++) begin
            bus.a_ready = (i == a_delay);
            chk("a_valid", bus.a_valid, 1);
            chk("a_opcode", bus.a_opcode, wr ? 0 : 4);
            chk("a_address", bus.a_address, addr);
            chk("a_size", bus.a_size, 64'(size));
            chk("a_mask", bus.a_mask, exp_mask);
            chk("a_data", bus.a_data, data);
            chk("a_source", bus.a_source, SRC);
            chk("a_corrupt", bus.a_corrupt, 0);
            chk("d_ready_in_req", bus.d_ready, 0);
            @(negedge clk);
        end
        bus.a_ready = 1'b0;
        for (int i = 0; i < d_delay && i < TMO; i++) begin
            bus.d_valid    = stray && (i == 0);
            bus.d_source   = 8'd5;
            bus.d_opcode   = wr ? 3'd0 : 3'd1;
            bus.d_denied   = 1'b0;
            bus.d_corrupt  = 1'b0;
            bus.d_data     = {$urandom, $urandom};
            chk("wait_d_ready", bus.d_ready, 1);
            chk("wait_a_valid", bus.a_valid, 0);
            chk("wait_no_rsp", rsp_valid, 0);
            @(negedge clk);
        end
        bus.d_valid = 1'b0;
        if (d_delay < int'(TMO)) begin
            bus.d_valid   = 1'b1;
            bus.d_source  = 8'(SRC);
            bus.d_opcode  = dop;
            bus.d_denied  = denied;
            bus.d_corrupt = corrupt;
            bus.d_data    = ddata;
            chk("beat_d_ready", bus.d_ready, 1);
            @(negedge clk);
            bus.d_valid = 1'b0;
            exp_err  = denied || corrupt || (dop != (wr ? 3'd0 : 3'd1));
            exp_data = (wr || exp_err) ? 64'd0 : ddata;
        end else begin
            exp_err  = 1'b1;
            exp_data = 64'd0;
        end
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_error", rsp_error, 64'(exp_err));
        chk("rsp_data", rsp_data, exp_data);
        chk("rsp_d_ready_low", bus.d_ready, 0);
        chk("rsp_req_ready", req_ready, 1);
        @(negedge clk);
        chk("rsp_one_pulse", rsp_valid, 0);
        chk("rsp_data_hold", rsp_data, exp_data);
        chk("rsp_error_hold", rsp_error, 64'(exp_err));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          wr;
        logic [1:0]  sz;
        logic [63:0] ad;
        logic [2:0]  op;
        rst_n         = 1'b0;
        req_valid     = 1'b0;
        req_write     = 1'b0;
        req_addr      = '0;
        req_size      = '0;
        req_data      = '0;
        bus.a_ready   = 1'b0;
        bus.d_valid   = 1'b0;
        bus.d_opcode  = '0;
        bus.d_source  = '0;
        bus.d_denied  = 1'b0;
        bus.d_data    = '0;
        bus.d_corrupt = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_error", rsp_error, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_a_valid", bus.a_valid, 0);
        chk("rst_d_ready", bus.d_ready, 0);
        chk("rst_a_address", bus.a_address, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Get 0x28 size 3, AccessAckData
        run_txn(1'b0, 64'h28, 2'd3, 64'h0, 0, 0, 3'd1, 1'b0, 1'b0, 64'h1122334455667788, 1'b0);
        // Put 0x104 size 2, AccessAck
        run_txn(1'b1, 64'h104, 2'd2, 64'hDEADBEEF, 0, 1, 3'd0, 1'b0, 1'b0, 64'h0, 1'b0);
        // Misaligned Get
        run_txn(1'b0, 64'h3, 2'd1, 64'h0, 0, 0, 3'd1, 1'b0, 1'b0, 64'h0, 1'b0);
        // a_ready low for 5 cycles
        run_txn(1'b0, 64'h40, 2'd2, 64'h55, 5, 2, 3'd1, 1'b0, 1'b0, 64'hCAFEF00D, 1'b0);
        // Timeout with a stray source-5 beat
        run_txn(1'b0, 64'h80, 2'd3, 64'h0, 0, TMO, 3'd1, 1'b0, 1'b0, 64'h0, 1'b1);
        // Beat arriving in the timeout cycle wins
        run_txn(1'b0, 64'h88, 2'd3, 64'h0, 0, TMO - 1, 3'd1, 1'b0, 1'b0, 64'h99, 1'b1);
        // Wrong opcode and denied
        run_txn(1'b1, 64'h10, 2'd3, 64'h1, 0, 0, 3'd1, 1'b0, 1'b0, 64'h0, 1'b0);
        run_txn(1'b0, 64'h12, 2'd1, 64'h0, 1, 0, 3'd1, 1'b1, 1'b0, 64'h77, 1'b0);

        // Reset pulse during S_RESP
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 64'h200;
        req_size  = 2'd3;
        @(negedge clk);
        req_valid   = 1'b0;
        bus.a_ready = 1'b1;
        @(negedge clk);
        bus.a_ready = 1'b0;
        chk("mid_d_ready", bus.d_ready, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_a_valid", bus.a_valid, 0);
        chk("mid_rst_d_ready", bus.d_ready, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < int'(TMO) + 3; i++) begin
            chk("post_rst_no_rsp", rsp_valid, 0);
            chk("post_rst_no_a", bus.a_valid, 0);
            @(negedge clk);
        end
        run_txn(1'b0, 64'h208, 2'd3, 64'h0, 0, 0, 3'd1, 1'b0, 1'b0, 64'h0123456789ABCDEF, 1'b0);

        for (int n = 0; n < 40; n++) begin
            wr = 1'($urandom);
            sz = 2'($urandom);
            ad = {$urandom, $urandom};
            if ($urandom_range(3) != 0) ad = ad & ~((64'd1 << sz) - 64'd1);
            op = wr ? 3'd0 : 3'd1;
            if ($urandom_range(7) == 0) op = 3'($urandom);
            run_txn(wr, ad, sz, {$urandom, $urandom}, int'($urandom_range(3)),
                    int'($urandom_range(TMO)), op, $urandom_range(7) == 0,
                    $urandom_range(7) == 0, {$urandom, $urandom}, 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
